// File: rtl/conv_writeback_pkg.sv
// Shared definitions for the CMAC write-back stage: operation codes, FSM states and
// the default result width.
package conv_writeback_pkg;

  localparam int WB_DATA_W = 16;

  // Same encoding the CMAC engine drives on op_type.
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_CONV1 = 3'd1,
    OP_CONV3 = 3'd2,
    OP_CONVP = 3'd3,
    OP_MPOOL = 3'd4,
    OP_APOOL = 3'd5
  } op_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/conv_writeback_wb_buffer.sv
// Burst holding buffer: parallel load of a whole burst, indexed single-word read.
// Build option WB_RELU_EN clamps negative words (including -0) to zero on load.
module wb_buffer #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 16,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_i,
  input  logic [DEPTH*DATA_W-1:0] load_data_i,
  input  logic [IDX_W-1:0]        rd_idx_i,
  output logic [DATA_W-1:0]       rd_data_o
);

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = load_data_i[i*DATA_W +: DATA_W];
`ifdef WB_RELU_EN
      if (mem_d[i][DATA_W-1]) mem_d[i] = '0;
`else
`endif
    end
  end

  // NOTE: the buffer is reset explicitly so a reset mid-burst leaves no stale data on the read port.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      mem_q <= '0;
    else if (load_i) mem_q <= mem_d;
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/conv_writeback.sv
// CMAC write-back stage: captures a burst once all selected valids are set, then drains it
// one word per cycle into the output FIFO with a running byte address.
module conv_writeback
  import conv_writeback_pkg::*;
#(
  parameter int BURST_LEN = 16,
  parameter int DATA_W    = WB_DATA_W,
  parameter int ADDR_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [2:0]                  op_type,
  input  logic                        layer_start,
  input  logic [ADDR_W-1:0]           base_addr,
  input  logic [BURST_LEN-1:0]        res_valid_0,
  input  logic [BURST_LEN-1:0]        res_valid_1,
  input  logic [BURST_LEN*DATA_W-1:0] res_bus_0,
  input  logic [BURST_LEN*DATA_W-1:0] res_bus_1,
  output logic                        res_ack,
  input  logic                        out_fifo_full,
  output logic                        out_fifo_wr_en,
  output logic [DATA_W-1:0]           out_fifo_din,
  output logic [ADDR_W-1:0]           wb_addr,
  output logic                        burst_done,
  output logic                        busy,
  output logic [ADDR_W-1:0]           word_cnt
);

  localparam int                DEPTH       = 2 * BURST_LEN;
  localparam int                IDX_W       = $clog2(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_SINGLE = IDX_W'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0]  LAST_PAIR   = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP   = ADDR_W'(DATA_W / 8);

  wb_state_e               state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d, last_idx_q, last_idx_d, sel_last;
  logic                    res_ack_q, res_ack_d;
  logic [ADDR_W-1:0]       wb_addr_q, wb_addr_d, word_cnt_q, word_cnt_d;
  logic                    ready, capture, load_layer, last_write;
  logic [DEPTH*DATA_W-1:0] load_data;

  // Bank selection; CONVP packs bank 0 ahead of bank 1.
  always_comb begin
    ready     = 1'b0;
    load_data = '0;
    sel_last  = LAST_SINGLE;
    case (op_type)
      OP_CONV1: begin
        ready = &res_valid_1;
        load_data[BURST_LEN*DATA_W-1:0] = res_bus_1;
      end
      OP_CONV3: begin
        ready = &res_valid_0;
        load_data[BURST_LEN*DATA_W-1:0] = res_bus_0;
      end
      OP_CONVP: begin
        ready     = (&res_valid_0) & (&res_valid_1);
        load_data = {res_bus_1, res_bus_0};
        sel_last  = LAST_PAIR;
      end
      default: ;
    endcase
  end

  // layer_start wins over a coincident ready cycle; capture follows one cycle later.
  assign load_layer = (state_q == ST_IDLE) && layer_start;
  assign capture    = (state_q == ST_IDLE) && ready && !layer_start;
  assign last_write = out_fifo_wr_en && (idx_q == last_idx_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (capture) state_d = ST_DRAIN;
      ST_DRAIN: if (last_write) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_fifo_wr_en = (state_q == ST_DRAIN) && !out_fifo_full;
    busy           = (state_q == ST_DRAIN);
    burst_done     = (state_q == ST_DONE);
  end

  // NOTE: every variable gets its hold value first so no path through the block infers a latch.
  always_comb begin
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    res_ack_d  = capture;
    wb_addr_d  = wb_addr_q;
    word_cnt_d = word_cnt_q;
    if (load_layer) begin
      wb_addr_d  = base_addr;
      word_cnt_d = '0;
    end
    if (capture) begin
      idx_d      = '0;
      last_idx_d = sel_last;
    end
    if (out_fifo_wr_en) begin
      idx_d     = idx_q + 1'b1;
      wb_addr_d = wb_addr_q + ADDR_STEP;
      if (word_cnt_q != '1) word_cnt_d = word_cnt_q + 1'b1;
    end
    if (state_q == ST_DONE) idx_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      last_idx_q <= '0;
      res_ack_q  <= 1'b0;
      wb_addr_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
      res_ack_q  <= res_ack_d;
      wb_addr_q  <= wb_addr_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  wb_buffer #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .IDX_W (IDX_W)
  ) u_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (capture),
    .load_data_i(load_data),
    .rd_idx_i   (idx_q),
    .rd_data_o  (out_fifo_din)
  );

  assign res_ack  = res_ack_q;
  assign wb_addr  = wb_addr_q;
  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_conv_writeback.sv
// Self-checking bench for conv_writeback: queue-based reference model compared every cycle,
// directed scenarios pinned with literal expectations, then randomized bursts.
`timescale 1ns/1ps
module tb_conv_writeback;
  import conv_writeback_pkg::*;

  localparam int BL = 16;
  localparam int DW = 16;
  localparam int AW = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [2:0]        op_type = 3'd0;
  logic              layer_start = 1'b0;
  logic [AW-1:0]     base_addr = '0;
  logic [BL-1:0]     res_valid_0 = '0, res_valid_1 = '0;
  logic [BL*DW-1:0]  res_bus_0 = '0, res_bus_1 = '0;
  logic              res_ack;
  logic              out_fifo_full = 1'b0;
  logic              out_fifo_wr_en;
  logic [DW-1:0]     out_fifo_din;
  logic [AW-1:0]     wb_addr;
  logic              burst_done, busy;
  logic [AW-1:0]     word_cnt;

  conv_writeback #(.BURST_LEN(BL), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .op_type(op_type), .layer_start(layer_start),
    .base_addr(base_addr), .res_valid_0(res_valid_0), .res_valid_1(res_valid_1),
    .res_bus_0(res_bus_0), .res_bus_1(res_bus_1), .res_ack(res_ack),
    .out_fifo_full(out_fifo_full), .out_fifo_wr_en(out_fifo_wr_en),
    .out_fifo_din(out_fifo_din), .wb_addr(wb_addr), .burst_done(burst_done),
    .busy(busy), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int full_mode = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    int            cyc;
  } wr_t;
  wr_t wlog[$];
  int  ack_cnt = 0;
  int  done_cnt = 0;
  int  done_cyc = 0;

  // Reference model: pending words of the burst in flight, address and count.
  logic [DW-1:0] m_q[$];
  logic [AW-1:0] m_addr = '0;
  logic [AW-1:0] m_cnt = '0;
  bit            m_ack = 0;
  bit            m_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [DW-1:0] exp_word(input logic [DW-1:0] w);
`ifdef WB_RELU_EN
    return w[DW-1] ? 16'h0000 : w;
`else
    return w;
`endif
  endfunction

  function automatic logic [DW-1:0] word_of(input logic [BL*DW-1:0] bus, input int i);
    return bus[i*DW +: DW];
  endfunction

  function automatic logic [BL*DW-1:0] ramp(input logic [DW-1:0] start);
    logic [BL*DW-1:0] r;
    for (int i = 0; i < BL; i++) r[i*DW +: DW] = start + DW'(i);
    return r;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_addr = '0;
    m_cnt  = '0;
    m_ack  = 0;
    m_done = 0;
  endtask

  // One clock edge of the specified behaviour, using the pre-edge inputs.
  task automatic model_step();
    bit rdy;
    m_ack = 0;
    if (m_done) begin
      m_done = 0;
    end else if (m_q.size() != 0) begin
      if (!out_fifo_full) begin
        m_q.delete(0);
        m_addr = m_addr + 2;
        if (m_cnt != '1) m_cnt = m_cnt + 1;
        if (m_q.size() == 0) m_done = 1;
      end
    end else if (layer_start) begin
      m_addr = base_addr;
      m_cnt  = '0;
    end else begin
      rdy = (op_type == 3'd1 && res_valid_1 == '1) ||
            (op_type == 3'd2 && res_valid_0 == '1) ||
            (op_type == 3'd3 && res_valid_0 == '1 && res_valid_1 == '1);
      if (rdy) begin
        m_ack = 1;
        if (op_type == 3'd2 || op_type == 3'd3)
          for (int i = 0; i < BL; i++) m_q.push_back(exp_word(word_of(res_bus_0, i)));
        if (op_type == 3'd1 || op_type == 3'd3)
          for (int i = 0; i < BL; i++) m_q.push_back(exp_word(word_of(res_bus_1, i)));
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Per-cycle comparison and write log, sampled mid-cycle.
  initial begin
    bit exp_busy;
    forever begin
      @(negedge clk);
      cycle++;
      if (rst_n) begin
        exp_busy = (m_q.size() != 0);
        check("wr_en", out_fifo_wr_en, exp_busy && !out_fifo_full);
        check("busy", busy, exp_busy);
        check("res_ack", res_ack, m_ack);
        check("burst_done", burst_done, m_done);
        check("wb_addr", wb_addr, m_addr);
        check("word_cnt", word_cnt, m_cnt);
        if (exp_busy && out_fifo_wr_en) check("din", out_fifo_din, m_q[0]);
        if (out_fifo_wr_en) wlog.push_back('{d: out_fifo_din, a: wb_addr, cyc: cycle});
        if (res_ack) ack_cnt++;
        if (burst_done) begin
          done_cnt++;
          done_cyc = cycle;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (full_mode)
        0:       out_fifo_full = 1'b0;
        1:       out_fifo_full = ~out_fifo_full;
        default: out_fifo_full = ($urandom_range(0, 2) == 0);
      endcase
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wlog.delete();
    ack_cnt  = 0;
    done_cnt = 0;
  endtask

  task automatic pulse_layer(input logic [AW-1:0] b);
    layer_start = 1'b1;
    base_addr   = b;
    tick();
    layer_start = 1'b0;
  endtask

  // Engine side: present a burst, hold valids until res_ack, then wait for burst_done.
  task automatic present(input logic [2:0] op, input logic [BL*DW-1:0] b0, input logic [BL*DW-1:0] b1,
                         input bit ls_same, input logic [AW-1:0] ls_base, input bit ls_busy);
    bit seen;
    op_type = op;
    res_bus_0 = b0;
    res_bus_1 = b1;
    res_valid_0 = '1;
    res_valid_1 = '1;
    if (ls_same) begin
      layer_start = 1'b1;
      base_addr   = ls_base;
    end
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      layer_start = 1'b0;
      if (res_ack) seen = 1;
    end
    check("ack_seen", seen, 1'b1);
    res_valid_0 = '0;
    res_valid_1 = '0;
    op_type   = 3'($urandom_range(0, 7));
    res_bus_0 = {8{$urandom()}};
    res_bus_1 = {8{$urandom()}};
    if (ls_busy) begin
      layer_start = 1'b1;
      base_addr   = $urandom();
      tick();
      layer_start = 1'b0;
    end
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (burst_done) seen = 1;
      else tick();
    end
    check("done_seen", seen, 1'b1);
    tick();
  endtask

  initial begin
    logic [BL*DW-1:0] b0;
    logic [BL-1:0]    pv;
    logic [2:0]       op;
    int               n;

    repeat (3) tick();
    #2 rst_n = 1'b1;
    tick();
    check("rst_word_cnt", word_cnt, 0);
    check("rst_wb_addr", wb_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_ack_done", {res_ack, burst_done, out_fifo_wr_en}, 0);

    // 1: CONV3 ramp at 0x1000, FIFO never full
    full_mode = 0;
    pulse_layer(32'h1000);
    clear_log();
    present(3'd2, ramp(16'h3C00), {8{$urandom()}}, 0, 0, 0);
    check("t1_writes", wlog.size(), 16);
    for (int i = 0; i < 16 && i < wlog.size(); i++) begin
      check("t1_data", wlog[i].d, 16'h3C00 + i);
      check("t1_addr", wlog[i].a, 32'h1000 + 2 * i);
    end
    check("t1_consecutive", wlog[15].cyc - wlog[0].cyc, 15);
    check("t1_acks", ack_cnt, 1);
    check("t1_dones", done_cnt, 1);
    check("t1_word_cnt", word_cnt, 16);

    // 2: CONVP, bank 0 then bank 1
    pulse_layer(32'h2000);
    clear_log();
    present(3'd3, ramp(16'h1000), ramp(16'h2000), 0, 0, 0);
    check("t2_writes", wlog.size(), 32);
    for (int i = 0; i < 32 && i < wlog.size(); i++)
      check("t2_data", wlog[i].d, (i < 16) ? (16'h1000 + i) : (16'h2000 + i - 16));
    check("t2_last_addr", wlog[31].a, 32'h203E);
    check("t2_dones", done_cnt, 1);

    // 3: CONV3 with the FIFO full every other cycle
    full_mode = 1;
    pulse_layer(32'h1000);
    clear_log();
    present(3'd2, ramp(16'h3C00), '0, 0, 0, 0);
    check("t3_writes", wlog.size(), 16);
    for (int i = 0; i < 16 && i < wlog.size(); i++) begin
      check("t3_data", wlog[i].d, 16'h3C00 + i);
      check("t3_addr", wlog[i].a, 32'h1000 + 2 * i);
    end
    check("t3_done_cycle", done_cyc, wlog[15].cyc + 1);
    full_mode = 0;

    // 4: reset after 5 writes of a burst
    pulse_layer(32'h3000);
    clear_log();
    op_type = 3'd2;
    res_bus_0 = ramp(16'h0100);
    res_valid_0 = '1;
    for (int i = 0; i < 40 && wlog.size() < 5; i++) tick();
    #3 rst_n = 1'b0;
    #1;
    check("t4_rst_outputs", {out_fifo_wr_en, busy, res_ack, burst_done}, 0);
    check("t4_rst_addr_cnt", {wb_addr, word_cnt}, 0);
    check("t4_rst_din", out_fifo_din, 0);
    res_valid_0 = '0;
    repeat (3) tick();
    #2 rst_n = 1'b1;
    n = wlog.size();
    repeat (20) tick();
    check("t4_no_writes", wlog.size(), n);
    pulse_layer(32'h3000);
    clear_log();
    present(3'd2, ramp(16'h0100), '0, 0, 0, 0);
    check("t4_after_writes", wlog.size(), 16);
    check("t4_after_addr", wlog[0].a, 32'h3000);
    check("t4_after_cnt", word_cnt, 16);

    // 5: ReLU on capture
    b0 = ramp(16'h3C00);
    b0[0*DW +: DW] = 16'hBC00;
    b0[1*DW +: DW] = 16'h8000;
    b0[2*DW +: DW] = 16'h3C00;
    clear_log();
    present(3'd2, b0, '0, 0, 0, 0);
`ifdef WB_RELU_EN
    check("t5_w0", wlog[0].d, 16'h0000);
    check("t5_w1", wlog[1].d, 16'h0000);
`else
    check("t5_w0", wlog[0].d, 16'hBC00);
    check("t5_w1", wlog[1].d, 16'h8000);
`endif
    check("t5_w2", wlog[2].d, 16'h3C00);

    // 6: back-to-back CONV1 bursts, one layer_start
    pulse_layer(32'h4000);
    clear_log();
    present(3'd1, '0, ramp(16'h5000), 0, 0, 0);
    present(3'd1, '0, ramp(16'h6000), 0, 0, 0);
    check("t6_writes", wlog.size(), 32);
    check("t6_second_addr", wlog[16].a, 32'h4020);
    check("t6_second_data", wlog[16].d, 16'h6000);
    check("t6_word_cnt", word_cnt, 32);

    // Randomized bursts: partial valids, invalid ops, layer_start collisions, address wrap.
    for (int it = 0; it < 40; it++) begin
      full_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 7) == 0) begin
        n = ack_cnt;
        op_type = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(4, 7));
        res_valid_0 = '1;
        res_valid_1 = '1;
        repeat (6) tick();
        res_valid_0 = '0;
        res_valid_1 = '0;
        check("invalid_op_no_ack", ack_cnt - n, 0);
        continue;
      end
      op = 3'($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0)
        pulse_layer(($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : $urandom());
      pv = '1;
      pv[$urandom_range(0, BL - 1)] = 1'b0;
      op_type = op;
      res_valid_0 = pv;
      res_valid_1 = pv;
      repeat ($urandom_range(0, 3)) tick();
      present(op, {8{$urandom()}}, {8{$urandom()}}, ($urandom_range(0, 3) == 0), $urandom(),
              ($urandom_range(0, 3) == 0));
    end

    full_mode = 0;
    repeat (4) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
